dma_fifo_drain_wr: RTL
======================

Name: dma_fifo_drain_wr

Overview:
- DMA write-side engine: the consumer end of the DMA staging FIFO.
- Pops words from the FIFO and issues one memory write per word to consecutive destination addresses until a programmed byte length has been written.
- Sits between the FIFO pop port and the memory write port; the read engine fills the FIFO, this block empties it.

Parameters:
- MEM_DATA_WIDTH, 32 (from dma_pkg): FIFO/memory data width in bits; BYTES = MEM_DATA_WIDTH/8.
- ADDR_WIDTH, 32: memory byte-address width.
- LEN_WIDTH, 16: transfer length field width, in bytes.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle transfer request; sampled only in IDLE.
- dst_addr  in  ADDR_WIDTH  destination byte address, BYTES-aligned; sampled with start.
- byte_len  in  LEN_WIDTH  transfer length in bytes; sampled with start.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle completion pulse.
- fifo_empty  in  1  FIFO empty flag.
- fifo_pop  out  1  FIFO pop request.
- fifo_rdata  in  MEM_DATA_WIDTH  FIFO pop data; valid the cycle after a pop.
- mem_wr_req  out  1  memory write request.
- mem_wr_addr  out  ADDR_WIDTH  write address.
- mem_wr_data  out  MEM_DATA_WIDTH  write data.
- mem_wr_gnt  in  1  write accepted in the cycle it is high together with mem_wr_req.

Behaviour:
- Reset (rstn=0 at posedge) puts the block in IDLE. All outputs go to 0, including mem_wr_addr and mem_wr_data. Internal counters are cleared. Reset mid-transfer aborts immediately: no done pulse, and no further pop or req.
- Word count is computed at start: words = ceil(byte_len/BYTES) = (byte_len + BYTES-1) >> log2(BYTES). This is computed at LEN_WIDTH+1 bits so byte_len = all-ones does not overflow.
- State IDLE: busy=0. If start=1 and words=0, go to DONE. If start=1 and words>0, latch the address and word count, then go to POP. Otherwise stay in IDLE.
- State POP: fifo_pop = ~fifo_empty, combinational. If fifo_empty=0, go to CAPT. Otherwise stay in POP. The block never pops while empty.
- State CAPT: register fifo_rdata into mem_wr_data and the current address into mem_wr_addr. Go to REQ.
- State REQ: mem_wr_req=1. Address and data are held stable until the grant.
  - If mem_wr_gnt=1: address += BYTES (wraps modulo 2^ADDR_WIDTH) and remaining -= 1.
  - After a grant, go to DONE if remaining was 1; otherwise go to POP.
  - No timeout; the block waits in REQ indefinitely.
- State DONE: done=1 for exactly one cycle, busy=1. Go to IDLE.
- start is ignored while busy. start coinciding with rstn=0 is ignored.
- fifo_pop and mem_wr_req are never high in the same cycle. There is at most one word in flight.
- Throughput is 3 cycles per word when the FIFO is non-empty and the grant arrives the same cycle.
- Single-word latency: start in cycle 0 → POP in cycle 1 (pop) → CAPT in cycle 2 → REQ in cycle 3 (gnt) → done=1 in cycle 4.
- The FIFO going empty mid-transfer stalls the block in POP; it resumes on the first non-empty cycle, with no data loss or duplication.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with start=1 → busy=done=fifo_pop=mem_wr_req=0 and mem_wr_addr=mem_wr_data=0; the block remains idle.
- Basic: FIFO preloaded with A0,A1,A2,A3; start with dst_addr=0x1000, byte_len=16, gnt tied 1 → writes (0x1000,A0), (0x1004,A1), (0x1008,A2), (0x100C,A3); exactly 4 pops; done pulses 1 cycle, 13 cycles after start.
- Rounding/zero: byte_len=5 → 2 writes. byte_len=0 → done pulses in the cycle after start with no pop and no req.
- Backpressure: gnt low for 5 cycles on the 2nd word → mem_wr_req stays 1 with address and data stable throughout; no extra pop; the write completes on the grant.
- Starvation: FIFO empty for 10 cycles after the 1st word → fifo_pop=0 while empty; data order is preserved; start pulses during busy are ignored.
- Abort/wrap: dst_addr=0xFFFFFFFC with byte_len=8 → the 2nd write goes to 0x00000000. Asserting rstn=0 in REQ → outputs clear next cycle, no done pulse, and a fresh start works.

Source files
------------

// File: rtl/dma_fifo_drain_wr_if.sv
// Handshake and bus bundle between the DMA control side, the staging FIFO
// pop port and the memory write port of the FIFO drain engine.
interface dma_fifo_drain_wr_if #(
   parameter int MEM_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int LEN_WIDTH      = 16
);
   logic                      start;
   logic [ADDR_WIDTH-1:0]     dst_addr;
   logic [LEN_WIDTH-1:0]      byte_len;
   logic                      busy;
   logic                      done;
   logic                      fifo_empty;
   logic                      fifo_pop;
   logic [MEM_DATA_WIDTH-1:0] fifo_rdata;
   logic                      mem_wr_req;
   logic [ADDR_WIDTH-1:0]     mem_wr_addr;
   logic [MEM_DATA_WIDTH-1:0] mem_wr_data;
   logic                      mem_wr_gnt;

   // Engine side: drives the FIFO pop and the memory write request.
   modport master (
      input  start, dst_addr, byte_len, fifo_empty, fifo_rdata, mem_wr_gnt,
      output busy, done, fifo_pop, mem_wr_req, mem_wr_addr, mem_wr_data
   );

   // Environment side: control, FIFO and memory.
   modport slave (
      output start, dst_addr, byte_len, fifo_empty, fifo_rdata, mem_wr_gnt,
      input  busy, done, fifo_pop, mem_wr_req, mem_wr_addr, mem_wr_data
   );
endinterface

// File: rtl/dma_fifo_drain_wr.sv
// DMA write-side engine: pops one word at a time from the staging FIFO and
// writes it to consecutive destination addresses until byte_len is covered.
// One word in flight at most: POP -> CAPT -> REQ per word.
module dma_fifo_drain_wr #(
   parameter int MEM_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int LEN_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   dma_fifo_drain_wr_if.master  bus
);
   localparam int BYTES = MEM_DATA_WIDTH / 8;
   localparam int SHIFT = $clog2(BYTES);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      POP  = 3'd1,
      CAPT = 3'd2,
      REQ  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t                    state_reg,   state_next;
   logic [ADDR_WIDTH-1:0]     addr_reg,    addr_next;
   logic [LEN_WIDTH:0]        remain_reg,  remain_next;
   logic [ADDR_WIDTH-1:0]     wr_addr_reg, wr_addr_next;
   logic [MEM_DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
   logic                      pop;
   logic                      req;
   logic [LEN_WIDTH:0]        words;

   // One extra bit so an all-ones byte_len rounds up without overflow.
   assign words = ({1'b0, bus.byte_len} + (LEN_WIDTH+1)'(BYTES-1)) >> SHIFT;

   // State and datapath registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         remain_reg  <= '0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         remain_reg  <= remain_next;
         wr_addr_reg <= wr_addr_next;
         wr_data_reg <= wr_data_next;
      end
   end

   // Next-state, counters and handshake strobes.
   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      remain_next  = remain_reg;
      wr_addr_next = wr_addr_reg;
      wr_data_next = wr_data_reg;
      pop          = 1'b0;
      req          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               if (words == '0) begin
                  state_next = DONE;
               end else begin
                  addr_next   = bus.dst_addr;
                  remain_next = words;
                  state_next  = POP;
               end
            end
         end
         POP: begin
            // Never pop an empty FIFO; wait here until data shows up.
            pop = ~bus.fifo_empty;
            if (!bus.fifo_empty) begin
               state_next = CAPT;
            end
         end
         CAPT: begin
            // Pop data is valid the cycle after the pop.
            wr_data_next = bus.fifo_rdata;
            wr_addr_next = addr_reg;
            state_next   = REQ;
         end
         REQ: begin
            // Address and data registers stay untouched until the grant.
            req = 1'b1;
            if (bus.mem_wr_gnt) begin
               addr_next   = addr_reg + ADDR_WIDTH'(BYTES);
               remain_next = remain_reg - (LEN_WIDTH+1)'(1);
               state_next  = (remain_reg == (LEN_WIDTH+1)'(1)) ? DONE : POP;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.fifo_pop    = pop;
   assign bus.mem_wr_req  = req;
   assign bus.mem_wr_addr = wr_addr_reg;
   assign bus.mem_wr_data = wr_data_reg;
   assign bus.busy        = (state_reg != IDLE);
   assign bus.done        = (state_reg == DONE);
endmodule
